instruction_memory_loadable: RTL and testbench
==============================================

Name: instruction_memory_loadable

Overview:
Parametrised, synchronous instruction memory for the MIPS datapath. It replaces fixed case-table program storage with a RAM array that a sequential program loader fills. Fetch uses a registered request/valid interface with stall support. The block sits between the PC register and the instruction decoder; the loader port is driven by the test harness or a boot controller.

Parameters:
DATA_WIDTH, 16, instruction word width in bits
ADDR_WIDTH, 8, fetch/load address width
DEPTH, 256, number of implemented words; must be <= 2**ADDR_WIDTH
NOP_WORD, 16'h0000, word returned for out-of-range fetches and after reset

Ports:
clk  in  1  system clock; all logic is rising-edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse; arms the loader and sets the write pointer to load_base
load_base  in  ADDR_WIDTH  first write address, sampled on load_start
load_valid  in  1  load_data is valid this cycle
load_data  in  DATA_WIDTH  word to write
load_busy  out  1  loader is in LOADING
load_full  out  1  loader stopped because the pointer reached DEPTH
load_count  out  ADDR_WIDTH+1  words written since the last load_start
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_WIDTH  word address
fetch_stall  in  1  hold the current fetch output
fetch_valid  out  1  fetch_data is valid
fetch_data  out  DATA_WIDTH  fetched instruction
fetch_fault  out  1  the last accepted fetch was out of range (addr >= DEPTH)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: fetch_valid=0, fetch_data=NOP_WORD, fetch_fault=0, load_busy=0, load_full=0, load_count=0.
  - Loader state goes to IDLE; pointer=0.
  - Memory array contents are not cleared.
- Loader FSM:
  - States: IDLE, LOADING, FULL.
  - IDLE -> LOADING on load_start. Pointer=load_base; load_count=0.
  - In LOADING, each load_valid writes load_data to mem[pointer], then pointer+1 and load_count+1.
  - After a write to address DEPTH-1, go to FULL. load_full=1. Further load_valid is ignored.
  - load_start in any state, including LOADING and FULL, restarts the loader from load_base. If load_start and load_valid occur in the same cycle, load_start wins and the data is dropped.
  - load_valid in IDLE is ignored.
  - load_base >= DEPTH goes directly to FULL with no write.
  - load_busy=1 only in LOADING.
- Fetch:
  - Latency is one cycle.
  - If fetch_req=1 and fetch_stall=0 at edge N, then at edge N+1: fetch_valid=1, fetch_data=mem[fetch_addr], fetch_fault=0.
  - If fetch_addr >= DEPTH, the response is instead fetch_data=NOP_WORD, fetch_fault=1.
  - fetch_req=0 with fetch_stall=0 sets fetch_valid=0. fetch_data holds its last value.
  - fetch_stall=1 holds fetch_valid, fetch_data and fetch_fault unchanged. A request made during a stall is not accepted; the requester must hold it.
  - Back-to-back requests give one word per cycle.
- Read/write collision: if a load write and an accepted fetch target the same address in the same cycle, the fetch returns the pre-write contents (read-old).
- Reset mid-load: loader returns to IDLE. Words already written remain in memory. An in-flight fetch response is discarded (fetch_valid=0).
- Width rule: load_count saturates at DEPTH and never wraps. The pointer never wraps past DEPTH-1.

Test Plan:
- Reset release then fetch_req at addr 0x00 -> fetch_valid=1 one cycle later; fetch_data equals the prior array contents. Before the request: fetch_data=16'h0000, fetch_valid=0.
- load_start with base 0x00, then 5 load_valid words 485A, 4A14, 4DF6, 4F96, 0880 -> load_count=5, load_busy=1. Fetches of 0x00..0x04 back-to-back return those words on 5 consecutive cycles; a fetch of 0x05 returns the old contents.
- load_start with base 0xFE and DEPTH=256, then 3 words -> 0xFE and 0xFF are written; load_full=1 after the 2nd write; the 3rd word is ignored; load_count=2.
- Fetch 0x01 with fetch_stall asserted on the next cycle for 3 cycles while fetch_addr changes to 0x02 -> fetch_data holds 4A14 for 4 cycles. 0x02 is returned only after the stall drops and the request is re-accepted.
- DEPTH=16: fetch addr 0x20 -> fetch_data=NOP_WORD, fetch_fault=1. A following fetch of 0x03 clears fetch_fault.
- Collision: load writes 0x1234 to 0x03 while fetching 0x03 (old value 4F96) -> returns 4F96. The next fetch of 0x03 returns 1234.
- rst_n pulsed low mid-load after 2 words -> load_busy=0, load_count=0, fetch_valid=0 immediately. The 2 written words are still fetchable afterwards.

Source files
------------

// File: rtl/instruction_memory_loadable.sv
// Instruction RAM with a sequential program loader and a registered fetch port.
// Latency: one cycle from an accepted fetch (fetch_req & ~fetch_stall) to fetch_valid/fetch_data.
// Backpressure: fetch_stall freezes the response registers and refuses new requests; the loader never stalls.
//
// Ports:
//   clk, rst_n                        rising-edge clock, asynchronous active-low reset
//   load_start, load_base             (re)arm the loader at load_base; load_start beats load_valid
//   load_valid, load_data             one word written per valid cycle while LOADING
//   load_busy, load_full, load_count  loader status; load_count saturates at DEPTH
//   fetch_req, fetch_addr, fetch_stall  fetch request and response hold
//   fetch_valid, fetch_data, fetch_fault  registered response; fault on addr >= DEPTH
module instruction_memory_loadable #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_busy,
  output logic                  load_full,
  output logic [ADDR_WIDTH:0]   load_count,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_fault
);

  // Address comparisons are done one bit wider so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_L  = (ADDR_WIDTH+1)'(DEPTH - 1);
  // Array index width; range checks above guarantee the dropped upper bits are zero.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } load_state_t;

  load_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic base_oor;
  logic ptr_last;
  logic fetch_in_range;

  assign base_oor       = ({1'b0, load_base} >= DEPTH_L);
  assign ptr_last       = ({1'b0, ptr_q} == LAST_L);
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);

  // Loader state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Loader next state; a restart takes priority over a same-cycle data beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (load_start) begin
      ptr_d   = load_base;
      count_d = '0;
      state_d = base_oor ? FULL : LOADING;
    end else if (state_q == LOADING && load_valid) begin
      wr_en = 1'b1;
      if (count_q != DEPTH_L) begin
        count_d = count_q + 1'b1;
      end
      // The last implemented word ends the load; the pointer stays put rather than wrapping.
      if (ptr_last) begin
        state_d = FULL;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  assign load_busy  = (state_q == LOADING);
  assign load_full  = (state_q == FULL);
  assign load_count = count_q;

  // Program storage is deliberately left out of reset so a reset mid-load keeps written words.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q[IDX_W-1:0]] <= load_data;
    end
  end

  // Fetch response registers. Reading mem with non-blocking update gives read-old on a
  // same-address load write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= NOP_WORD;
      fetch_fault <= 1'b0;
    end else if (!fetch_stall) begin
      fetch_valid <= fetch_req;
      if (fetch_req) begin
        if (fetch_in_range) begin
          fetch_data  <= mem[fetch_addr[IDX_W-1:0]];
          fetch_fault <= 1'b0;
        end else begin
          fetch_data  <= NOP_WORD;
          fetch_fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
module tb_instruction_memory_loadable;

  logic        clk;
  logic        rst_n;

  // Main instance, DEPTH=256
  logic        load_start, load_valid, load_busy, load_full;
  logic [7:0]  load_base;
  logic [15:0] load_data;
  logic [8:0]  load_count;
  logic        fetch_req, fetch_stall, fetch_valid, fetch_fault;
  logic [7:0]  fetch_addr;
  logic [15:0] fetch_data;

  // Small instance, DEPTH=16
  logic        s_load_start, s_load_valid, s_load_busy, s_load_full;
  logic [7:0]  s_load_base;
  logic [15:0] s_load_data;
  logic [8:0]  s_load_count;
  logic        s_fetch_req, s_fetch_stall, s_fetch_valid, s_fetch_fault;
  logic [7:0]  s_fetch_addr;
  logic [15:0] s_fetch_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } fvec_t;

  fvec_t vecs [5];

  instruction_memory_loadable #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid), .load_data(load_data),
    .load_busy(load_busy), .load_full(load_full), .load_count(load_count),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault)
  );

  instruction_memory_loadable #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(16), .NOP_WORD(16'h0000)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .load_start(s_load_start), .load_base(s_load_base), .load_valid(s_load_valid), .load_data(s_load_data),
    .load_busy(s_load_busy), .load_full(s_load_full), .load_count(s_load_count),
    .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr), .fetch_stall(s_fetch_stall),
    .fetch_valid(s_fetch_valid), .fetch_data(s_fetch_data), .fetch_fault(s_fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'h00, 16'h485A};
    vecs[1] = '{8'h01, 16'h4A14};
    vecs[2] = '{8'h02, 16'h4DF6};
    vecs[3] = '{8'h03, 16'h4F96};
    vecs[4] = '{8'h04, 16'h0880};

    rst_n = 1'b0;
    load_start = 0; load_base = 0; load_valid = 0; load_data = 0;
    fetch_req = 0; fetch_addr = 0; fetch_stall = 0;
    s_load_start = 0; s_load_base = 0; s_load_valid = 0; s_load_data = 0;
    s_fetch_req = 0; s_fetch_addr = 0; s_fetch_stall = 0;
    #12;
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_data",  32'(fetch_data),  32'h0000);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst_load_busy",   32'(load_busy),   32'd0);
    chk("rst_load_full",   32'(load_full),   32'd0);
    chk("rst_load_count",  32'(load_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // First fetch after reset
    fetch_req = 1; fetch_addr = 8'h00;
    tick();
    chk("first_fetch_valid", 32'(fetch_valid), 32'd1);
    fetch_req = 0;
    tick();
    chk("idle_fetch_valid", 32'(fetch_valid), 32'd0);

    // Load five words at base 0
    load_start = 1; load_base = 8'h00;
    tick();
    load_start = 0;
    chk("load0_busy", 32'(load_busy), 32'd1);
    chk("load0_count_start", 32'(load_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_data = vecs[i].data;
      tick();
    end
    load_valid = 0;
    chk("load0_count", 32'(load_count), 32'd5);
    chk("load0_busy_after", 32'(load_busy), 32'd1);

    // Back-to-back table fetches
    for (int i = 0; i < 5; i++) begin
      fetch_req = 1; fetch_addr = vecs[i].addr;
      tick();
      chk($sformatf("b2b_valid_%0d", i), 32'(fetch_valid), 32'd1);
      chk($sformatf("b2b_data_%0d", i), 32'(fetch_data), 32'(vecs[i].data));
    end
    fetch_req = 0;
    tick();
    chk("hold_valid", 32'(fetch_valid), 32'd0);
    chk("hold_data", 32'(fetch_data), 32'h0880);

    // Load near the top: third word must be ignored
    load_start = 1; load_base = 8'hFE;
    tick();
    load_start = 0;
    load_valid = 1; load_data = 16'hAAAA;
    tick();
    chk("top_count1", 32'(load_count), 32'd1);
    chk("top_full1", 32'(load_full), 32'd0);
    load_data = 16'hBBBB;
    tick();
    chk("top_full2", 32'(load_full), 32'd1);
    chk("top_busy2", 32'(load_busy), 32'd0);
    chk("top_count2", 32'(load_count), 32'd2);
    load_data = 16'hCCCC;
    tick();
    load_valid = 0;
    chk("top_count3", 32'(load_count), 32'd2);
    chk("top_full3", 32'(load_full), 32'd1);
    fetch_req = 1; fetch_addr = 8'hFE;
    tick();
    chk("top_fe", 32'(fetch_data), 32'hAAAA);
    fetch_addr = 8'hFF;
    tick();
    chk("top_ff", 32'(fetch_data), 32'hBBBB);
    fetch_addr = 8'h00;
    tick();
    chk("top_no_wrap", 32'(fetch_data), 32'h485A);

    // Stall hold
    fetch_addr = 8'h01;
    tick();
    chk("stall_first", 32'(fetch_data), 32'h4A14);
    fetch_stall = 1; fetch_addr = 8'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_data_%0d", i), 32'(fetch_data), 32'h4A14);
      chk($sformatf("stall_valid_%0d", i), 32'(fetch_valid), 32'd1);
    end
    fetch_stall = 0;
    tick();
    chk("stall_release", 32'(fetch_data), 32'h4DF6);
    fetch_req = 0;

    // Collision: write 0x1234 to 0x03 while fetching 0x03
    load_start = 1; load_base = 8'h03;
    tick();
    load_start = 0;
    load_valid = 1; load_data = 16'h1234;
    fetch_req = 1; fetch_addr = 8'h03;
    tick();
    load_valid = 0;
    chk("collide_old", 32'(fetch_data), 32'h4F96);
    tick();
    chk("collide_new", 32'(fetch_data), 32'h1234);
    fetch_req = 0;

    // load_start wins over same-cycle load_valid
    load_start = 1; load_base = 8'h10; load_valid = 1; load_data = 16'hDEAD;
    tick();
    load_start = 0;
    chk("start_wins_count", 32'(load_count), 32'd0);
    load_data = 16'hFACE;
    tick();
    load_valid = 0;
    chk("start_wins_count1", 32'(load_count), 32'd1);
    fetch_req = 1; fetch_addr = 8'h10;
    tick();
    chk("start_wins_data", 32'(fetch_data), 32'hFACE);
    fetch_req = 0;

    // Small instance: out-of-range base, out-of-range fetch, fault clear
    s_load_start = 1; s_load_base = 8'h20;
    tick();
    chk("s_oor_base_full", 32'(s_load_full), 32'd1);
    chk("s_oor_base_busy", 32'(s_load_busy), 32'd0);
    s_load_base = 8'h03;
    tick();
    s_load_start = 0;
    s_load_valid = 1; s_load_data = 16'h5A5A;
    tick();
    s_load_valid = 0;
    s_fetch_req = 1; s_fetch_addr = 8'h20;
    tick();
    chk("s_oor_valid", 32'(s_fetch_valid), 32'd1);
    chk("s_oor_data", 32'(s_fetch_data), 32'h0000);
    chk("s_oor_fault", 32'(s_fetch_fault), 32'd1);
    s_fetch_addr = 8'h03;
    tick();
    chk("s_clr_fault", 32'(s_fetch_fault), 32'd0);
    chk("s_clr_data", 32'(s_fetch_data), 32'h5A5A);
    s_fetch_req = 0;

    // Reset mid-load with a fetch in flight
    load_start = 1; load_base = 8'h20;
    tick();
    load_start = 0;
    load_valid = 1; load_data = 16'h1111;
    tick();
    load_data = 16'h2222;
    fetch_req = 1; fetch_addr = 8'h00;
    tick();
    load_valid = 0; fetch_req = 0;
    chk("pre_rst_valid", 32'(fetch_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(load_busy), 32'd0);
    chk("mid_rst_count", 32'(load_count), 32'd0);
    chk("mid_rst_valid", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // load_valid in IDLE does nothing
    load_valid = 1; load_data = 16'h9999;
    tick();
    load_valid = 0;
    chk("idle_valid_count", 32'(load_count), 32'd0);
    chk("idle_valid_busy", 32'(load_busy), 32'd0);
    fetch_req = 1; fetch_addr = 8'h20;
    tick();
    chk("kept_20", 32'(fetch_data), 32'h1111);
    fetch_addr = 8'h21;
    tick();
    chk("kept_21", 32'(fetch_data), 32'h2222);
    fetch_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
